// File: rtl/regfile_bist.sv
// regfile_bist: march-style self-test engine for the 32x32 register file.
// Writes a pattern, reads it back on both ports, then repeats inverted.
module regfile_bist #(
  parameter int              DW       = 32,
  parameter int              AWID     = 5,
  parameter logic [DW-1:0]   SEED     = '0,
  parameter int              READ_LAT = 1,
  parameter bit              ZERO_R0  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [DW-1:0]     WD3,
  output logic [AWID-1:0]   AW,
  output logic [AWID-1:0]   AR_1,
  output logic [AWID-1:0]   AR_2,
  output logic              RD,
  output logic              WR,
  output logic              EN,
  input  logic [DW-1:0]     RD1,
  input  logic [DW-1:0]     RD2,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [5:0]        err_count,
  output logic [AWID-1:0]   first_fail_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [AWID-1:0] LAST     = '1;
  localparam logic [AWID-1:0] DRN_LAST = AWID'(READ_LAT - 1);

  state_t            state_q, state_d;
  logic [AWID-1:0]   addr_q, addr_d;
  logic              p_q, p_d;

  logic [DW-1:0]     wd3_q, wd3_d;
  logic [AWID-1:0]   aw_q, aw_d;
  logic [AWID-1:0]   ar1_q, ar1_d;
  logic [AWID-1:0]   ar2_q, ar2_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [5:0]        err_q, err_d;
  logic [AWID-1:0]   ffa_q, ffa_d;

  // Compare pipeline: valid, pattern phase and both issued addresses
  logic [READ_LAT-1:0] pv_q, pv_d;
  logic [READ_LAT-1:0] pp_q, pp_d;
  logic [AWID-1:0]     pa1_q [READ_LAT];
  logic [AWID-1:0]     pa1_d [READ_LAT];
  logic [AWID-1:0]     pa2_q [READ_LAT];
  logic [AWID-1:0]     pa2_d [READ_LAT];

  logic              m1, m2;
  logic              go;
  logic [6:0]        err_sum;

  // Expected content of address a for the given pattern phase
  function automatic logic [DW-1:0] pat_f(
    input logic [AWID-1:0] a,
    input logic            inv
  );
    logic [DW-1:0] v;
    v = '0;
    v[AWID-1:0] = a;
    v = v + SEED;
    if (inv) v = ~v;
    if (ZERO_R0 && a == '0) v = '0;
    return v;
  endfunction

  // Sequencer: next state, address and pattern phase
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    p_d     = p_q;
    go      = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          go      = 1'b1;
          state_d = S_WRITE;
          addr_d  = '0;
          p_d     = 1'b0;
        end
      end
      S_WRITE: begin
        if (addr_q == LAST) begin
          state_d = S_READ;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_READ: begin
        if (addr_q == LAST) begin
          state_d = S_DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (addr_q == DRN_LAST) begin
          addr_d = '0;
          if (!p_q) begin
            p_d     = 1'b1;
            state_d = S_WRITE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // Register-file port values for the cycle being entered
  always_comb begin
    wr_d   = (state_d == S_WRITE);
    rd_d   = (state_d == S_READ) || (state_d == S_DRAIN);
    en_d   = wr_d || rd_d;
    busy_d = wr_d || rd_d;
    aw_d   = wr_d ? addr_d : '0;
    wd3_d  = wr_d ? pat_f(addr_d, p_d) : '0;
    ar1_d  = (state_d == S_READ) ? addr_d : '0;
    ar2_d  = (state_d == S_READ) ? (LAST - addr_d) : '0;
  end

  // Shift issued reads down the compare pipeline
  always_comb begin
    pv_d     = '0;
    pp_d     = '0;
    pv_d[0]  = (state_d == S_READ);
    pp_d[0]  = p_d;
    pa1_d[0] = ar1_d;
    pa2_d[0] = ar2_d;
    for (int i = 1; i < READ_LAT; i++) begin
      pv_d[i]  = pv_q[i-1];
      pp_d[i]  = pp_q[i-1];
      pa1_d[i] = pa1_q[i-1];
      pa2_d[i] = pa2_q[i-1];
    end
  end

  // Retire the oldest read: compare, count, and latch the first failure
  always_comb begin
    m1 = pv_q[READ_LAT-1] &&
         (RD1 != pat_f(pa1_q[READ_LAT-1], pp_q[READ_LAT-1]));
    m2 = pv_q[READ_LAT-1] &&
         (RD2 != pat_f(pa2_q[READ_LAT-1], pp_q[READ_LAT-1]));
    err_sum = {1'b0, err_q} + 7'(m1) + 7'(m2);
    err_d   = err_q;
    ffa_d   = ffa_q;
    if (go) begin
      err_d = '0;
      ffa_d = '0;
    end else begin
      err_d = (err_sum > 7'd63) ? 6'd63 : err_sum[5:0];
      if (err_q == '0 && (m1 || m2)) ffa_d = m1 ? pa1_q[READ_LAT-1] : pa2_q[READ_LAT-1];
    end
    done_d = (state_d == S_DONE);
    pass_d = (state_d == S_DONE) && (err_d == '0);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      p_q     <= 1'b0;
      wd3_q   <= '0;
      aw_q    <= '0;
      ar1_q   <= '0;
      ar2_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffa_q   <= '0;
      pv_q    <= '0;
      pp_q    <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        pa1_q[i] <= '0;
        pa2_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      p_q     <= p_d;
      wd3_q   <= wd3_d;
      aw_q    <= aw_d;
      ar1_q   <= ar1_d;
      ar2_q   <= ar2_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffa_q   <= ffa_d;
      pv_q    <= pv_d;
      pp_q    <= pp_d;
      for (int i = 0; i < READ_LAT; i++) begin
        pa1_q[i] <= pa1_d[i];
        pa2_q[i] <= pa2_d[i];
      end
    end
  end

  assign WD3             = wd3_q;
  assign AW              = aw_q;
  assign AR_1            = ar1_q;
  assign AR_2            = ar2_q;
  assign RD              = rd_q;
  assign WR              = wr_q;
  assign EN              = en_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_fail_addr = ffa_q;

endmodule

// File: tb/tb_regfile_bist.sv
// tb_regfile_bist: directed checks of regfile_bist against small
// behavioural register files (clean, stuck bit, dead, r0-zero + 2-cycle read).
module tb_regfile_bist;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  int          mode = 0;

  logic [31:0] wd3_a, rd1_a, rd2_a;
  logic [4:0]  aw_a, ar1_a, ar2_a, ffa_a;
  logic        rd_a, wr_a, en_a, busy_a, done_a, pass_a;
  logic [5:0]  err_a;

  logic [31:0] wd3_b, rd1_b, rd2_b;
  logic [4:0]  aw_b, ar1_b, ar2_b, ffa_b;
  logic        rd_b, wr_b, en_b, busy_b, done_b, pass_b;
  logic [5:0]  err_b;

  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;

  always #5 clk = ~clk;

  regfile_bist u_dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .WD3(wd3_a), .AW(aw_a), .AR_1(ar1_a), .AR_2(ar2_a),
    .RD(rd_a), .WR(wr_a), .EN(en_a),
    .RD1(rd1_a), .RD2(rd2_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_fail_addr(ffa_a)
  );

  regfile_bist #(.READ_LAT(2), .ZERO_R0(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .WD3(wd3_b), .AW(aw_b), .AR_1(ar1_b), .AR_2(ar2_b),
    .RD(rd_b), .WR(wr_b), .EN(en_b),
    .RD1(rd1_b), .RD2(rd2_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_fail_addr(ffa_b)
  );

  // File A: combinational read; mode 1 = bit 3 of reg 7 stuck at 0, mode 2 = dead
  always_ff @(posedge clk) if (en_a && wr_a) mem_a[aw_a] <= wd3_a;

  always_comb begin
    rd1_a = mem_a[ar1_a];
    rd2_a = mem_a[ar2_a];
    if (mode == 1) begin
      if (ar1_a == 5'd7) rd1_a[3] = 1'b0;
      if (ar2_a == 5'd7) rd2_a[3] = 1'b0;
    end
    if (mode == 2) begin
      rd1_a = '0;
      rd2_a = '0;
    end
  end

  // File B: r0 hardwired to zero, one registered read stage (2-cycle latency)
  always_ff @(posedge clk) begin
    if (en_b && wr_b && aw_b != 5'd0) mem_b[aw_b] <= wd3_b;
    rd1_b <= (ar1_b == 5'd0) ? 32'd0 : mem_b[ar1_b];
    rd2_b <= (ar2_b == 5'd0) ? 32'd0 : mem_b[ar2_b];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit sel_b);
    @(negedge clk);
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Count edges after the start edge until done; optional re-pulse of start_a
  task automatic run_wait(input bit sel_b, input int repulse, output int n);
    n = 0;
    while (!(sel_b ? done_b : done_a) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      start_a = (!sel_b && n == repulse);
    end
    start_a = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_err", err_a, 0);
    check("rst_ctl", {en_a, wr_a, rd_a}, 0);
    check("rst_addr", {aw_a, ar1_a, ar2_a, ffa_a}, 0);
    check("rst_wd3", wd3_a, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Clean run, defaults
    mode = 0;
    pulse_start(1'b0);
    check("start_busy", busy_a, 1);
    check("start_wr", {en_a, wr_a, rd_a}, 3'b110);
    check("start_aw", aw_a, 0);
    check("start_wd3", wd3_a, 0);
    run_wait(1'b0, -1, cyc);
    check("clean_cycles", cyc, 130);
    check("clean_pass", pass_a, 1);
    check("clean_err", err_a, 0);
    check("clean_ffa", ffa_a, 0);
    check("clean_busy", busy_a, 0);
    check("clean_ctl", {en_a, wr_a, rd_a}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", done_a, 1);

    // Stuck bit 3 of reg 7
    mode = 1;
    pulse_start(1'b0);
    check("restart_done_clr", done_a, 0);
    run_wait(1'b0, -1, cyc);
    check("stuck_cycles", cyc, 130);
    check("stuck_err", err_a, 2);
    check("stuck_ffa", ffa_a, 7);
    check("stuck_pass", pass_a, 0);

    // Dead file
    mode = 2;
    pulse_start(1'b0);
    run_wait(1'b0, -1, cyc);
    check("dead_err", err_a, 63);
    check("dead_ffa", ffa_a, 31);
    check("dead_pass", pass_a, 0);

    // Reset mid-WRITE
    mode = 0;
    pulse_start(1'b0);
    repeat (9) @(posedge clk);
    #3;
    check("pre_rst_wr", wr_a, 1);
    rst = 1'b1;
    #1;
    check("arst_ctl", {en_a, wr_a, rd_a}, 0);
    check("arst_busy", busy_a, 0);
    check("arst_aw", {aw_a, wd3_a}, 0);
    check("arst_res", {done_a, pass_a, err_a, ffa_a}, 0);
    @(negedge clk);
    rst = 1'b0;
    pulse_start(1'b0);
    run_wait(1'b0, -1, cyc);
    check("rerun_cycles", cyc, 130);
    check("rerun_pass", pass_a, 1);

    // start again at cycle 40 is ignored
    pulse_start(1'b0);
    run_wait(1'b0, 39, cyc);
    check("repulse_cycles", cyc, 130);
    check("repulse_pass", pass_a, 1);
    check("repulse_err", err_a, 0);

    // ZERO_R0 with r0 hardwired, READ_LAT=2
    pulse_start(1'b1);
    check("b_busy", busy_b, 1);
    run_wait(1'b1, -1, cyc);
    check("b_cycles", cyc, 132);
    check("b_pass", pass_b, 1);
    check("b_err", err_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
